rs_enc: RTL and testbench

Systematic Reed-Solomon encoder over GF(2^8), producing the 4-parity-symbol (t=2) codewords that the team's RS decoder consumes. It accepts a stream of message symbols with a valid/ready handshake. Each message symbol passes through with one cycle of latency, then the block appends 4 parity symbols computed by an LFSR division. It sits in the BER simulation transmit path, between the PRBS/data source and the channel/error-injection stage.

---
 rtl/rs_enc.sv | 102 ++++++++++
 tb/tb_rs_enc.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rs_enc.sv
// Systematic RS(n, n-4) encoder over GF(2^8), poly 0x11D, g(x) roots 1..a^3.
// Message symbols pass through with one cycle of latency, then 4 parity symbols follow.
module rs_enc (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] k,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_par,
  output logic       out_last
);

  typedef enum logic [1:0] {S_IDLE, S_MSG, S_PAR} state_t;

  state_t     r_state, w_next;
  logic [7:0] r_klen, r_cnt;
  logic [1:0] r_pcnt;
  logic [7:0] r_p0, r_p1, r_p2, r_p3;

  logic       w_accept, w_msg_done;
  logic [7:0] w_klen_in, w_klen, w_cnt_nxt, w_fb;

  // Constant-operand GF(2^8) multiply; with b fixed this folds to an XOR network.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return acc;
  endfunction

  assign in_ready   = (r_state != S_PAR);
  assign w_accept   = in_valid & in_ready;
  assign w_klen_in  = (k < 8'd5) ? 8'd5 : k;
  // First symbol of a frame uses the live k; later symbols use the latched length.
  assign w_klen     = (r_state == S_IDLE) ? w_klen_in : r_klen;
  assign w_cnt_nxt  = (r_state == S_IDLE) ? 8'd1 : r_cnt + 8'd1;
  assign w_msg_done = (w_cnt_nxt == w_klen - 8'd4);
  assign w_fb       = in_data ^ r_p3;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_MSG: if (w_accept) w_next = w_msg_done ? S_PAR : S_MSG;
      S_PAR:         if (r_pcnt == 2'd3) w_next = S_IDLE;
      default:       w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_klen    <= 8'd0;
      r_cnt     <= 8'd0;
      r_pcnt    <= 2'd0;
      r_p0      <= 8'd0;
      r_p1      <= 8'd0;
      r_p2      <= 8'd0;
      r_p3      <= 8'd0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      out_par   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_par   <= 1'b0;
      out_last  <= 1'b0;
      if (w_accept) begin
        r_klen    <= w_klen;
        r_cnt     <= w_cnt_nxt;
        r_p3      <= r_p2 ^ gf_mul(w_fb, 8'h0F);
        r_p2      <= r_p1 ^ gf_mul(w_fb, 8'h36);
        r_p1      <= r_p0 ^ gf_mul(w_fb, 8'h78);
        r_p0      <= gf_mul(w_fb, 8'h40);
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else if (r_state == S_PAR) begin
        // Drain parity highest-degree first; zeros shifted in leave the regs clear.
        out_valid <= 1'b1;
        out_data  <= r_p3;
        out_par   <= 1'b1;
        out_last  <= (r_pcnt == 2'd3);
        r_p3      <= r_p2;
        r_p2      <= r_p1;
        r_p1      <= r_p0;
        r_p0      <= 8'd0;
        r_pcnt    <= r_pcnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_rs_enc.sv
// Bench for rs_enc: directed and random frames checked against a polynomial
// long-division reference of m(x)*x^4 mod g(x).
module tb_rs_enc;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_par, out_last;
  logic [7:0] k, in_data, out_data;

  int checks = 0, errors = 0, cyc = 0;
  logic [9:0] obs_q[$], exp_q[$];
  int         cyc_q[$];

  always #5 clk = ~clk;

  rs_enc dut (
    .clk(clk), .rst(rst), .k(k), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_par(out_par), .out_last(out_last)
  );

  always @(negedge clk) begin
    cyc++;
    if (out_valid) begin
      obs_q.push_back({out_last, out_par, out_data});
      cyc_q.push_back(cyc);
    end
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'd0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h11D << (i - 8));
    return prod[7:0];
  endfunction

  // Remainder of m(x)*x^4 divided by monic g(x), highest-degree coefficient first.
  function automatic void ref_parity(input logic [7:0] msg[$], output logic [7:0] par[4]);
    logic [7:0] c[$];
    logic [7:0] g[5];
    logic [7:0] f;
    g = '{8'h01, 8'h0F, 8'h36, 8'h78, 8'h40};
    c = msg;
    repeat (4) c.push_back(8'h00);
    for (int i = 0; i < msg.size(); i++) begin
      f = c[i];
      for (int j = 1; j <= 4; j++) c[i+j] = c[i+j] ^ gmul(f, g[j]);
    end
    for (int j = 0; j < 4; j++) par[j] = c[msg.size()+j];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_frame(input int kk, input logic [7:0] msg[$], input logic [7:0] par[4],
                             input bit rnd, input bit hold);
    int idx = 0, guard = 0, low = 0;
    bit acc;
    k = kk[7:0];
    while (idx < msg.size() && guard < 4000) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = msg[idx];
      acc      = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        if (idx == 0) k = 8'($urandom);
        exp_q.push_back({2'b00, msg[idx]});
        idx++;
      end
      guard++;
    end
    chk("accept_all", idx, msg.size());
    while (!in_ready && low < 10) begin
      in_valid = hold;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
      low++;
    end
    in_valid = 1'b0;
    chk("ready_low_cycles", low, 4);
    for (int j = 0; j < 4; j++) exp_q.push_back({(j == 3), 1'b1, par[j]});
  endtask

  task automatic check_stream(input string tag, input bit contig);
    int g = 0;
    while (obs_q.size() < exp_q.size() && g < 2000) begin @(negedge clk); g++; end
    repeat (3) @(negedge clk);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({tag, "_sym"}, obs_q[i], exp_q[i]);
    if (contig && obs_q.size() > 1)
      chk({tag, "_nogap"}, cyc_q[obs_q.size()-1] - cyc_q[0], obs_q.size() - 1);
    obs_q.delete(); exp_q.delete(); cyc_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] m[$], m2[$];
    logic [7:0] p[4], p1[4], p2[4], pz[4];
    int kk;
    p1 = '{8'h0F, 8'h36, 8'h78, 8'h40};
    p2 = '{8'h1E, 8'h6C, 8'hF0, 8'h80};
    pz = '{8'h00, 8'h00, 8'h00, 8'h00};
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; k = 8'd5;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_par", out_par, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 1);

    m = {8'h01};
    drive_frame(5, m, p1, 0, 0);
    check_stream("k5_01", 1);

    m = {8'h02};
    drive_frame(5, m, p2, 0, 0);
    check_stream("k5_02", 1);

    m.delete();
    repeat (251) m.push_back(8'h00);
    m2 = {8'h01};
    drive_frame(255, m, pz, 0, 0);
    drive_frame(5, m2, p1, 0, 0);
    check_stream("k255_b2b", 1);

    for (int f = 0; f < 6; f++) begin
      kk = (f == 0) ? 20 : int'($urandom_range(5, 60));
      m.delete();
      repeat (kk - 4) m.push_back(8'($urandom));
      ref_parity(m, p);
      drive_frame(kk, m, p, 1, f[0]);
      check_stream("rand", 0);
    end

    m = {8'h02};
    drive_frame(2, m, p2, 0, 1);
    check_stream("k_illegal", 1);

    k = 8'd10; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'($urandom | 1);
      @(posedge clk); #1;
    end
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_out_par", out_par, 0);
    chk("abort_out_last", out_last, 0);
    chk("abort_in_ready", in_ready, 1);
    @(negedge clk);
    obs_q.delete(); exp_q.delete(); cyc_q.delete();
    @(posedge clk); #1;
    m = {8'h01};
    drive_frame(5, m, p1, 0, 0);
    check_stream("after_abort", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
